tx_os_generator: RTL and testbench



---
 rtl/tx_os_generator.sv | 197 +++++++++++++++++++
 tb/tb_tx_os_generator.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/tx_os_generator.sv
// Per-lane TS1/TS2/idle ordered-set transmitter for the LTSSM substates.
// Words use the same byte layout and substate encoding as the RX checker.
module tx_os_generator #(
  parameter int MIN_TS1 = 1024,
  parameter int POST_TS = 16,
  parameter int CNT_W   = 11
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [3:0]   substate,
  input  logic [7:0]   linkNumber,
  input  logic [7:0]   laneNumber,
  input  logic [7:0]   rateId,
  input  logic         upconfig,
  input  logic         rxDone,
  input  logic         txReady,
  output logic [127:0] orderedset,
  output logic         valid,
  output logic         txElecIdle,
  output logic         txDone
);

  localparam logic [7:0] PAD    = 8'hF7;
  localparam logic [7:0] ID_TS1 = 8'h2A;
  localparam logic [7:0] ID_TS2 = 8'h25;
  localparam logic [7:0] BYTE4  = 8'hAA;

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] MIN_CNT  = CNT_W'(MIN_TS1);
  localparam logic [CNT_W-1:0] POST_CNT = CNT_W'(POST_TS);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEND,
    S_POST,
    S_DONE
  } state_t;

  state_t state, state_n;

  logic [3:0]       sub_q, sub_n, sub_in;
  logic [7:0]       link_q, link_n;
  logic [7:0]       lane_q, lane_n;
  logic [7:0]       rate_q, rate_n;
  logic             upc_q, upc_n;
  logic [CNT_W-1:0] cnt, cnt_n, cnt_inc;
  logic             rx_seen, rx_seen_n;
  logic             rx_now;
  logic             sent;
  logic             valid_n;
  logic [127:0]     word_n;

  function automatic logic active(input logic [3:0] sub);
    return (sub >= 4'd2) && (sub <= 4'd9);
  endfunction

  function automatic logic [127:0] build_word(
    input logic [3:0] sub,
    input logic [7:0] link,
    input logic [7:0] lane,
    input logic [7:0] rate,
    input logic       upc
  );
    logic [7:0] id;
    logic [7:0] lk;
    logic [7:0] ln;
    logic       ts;
    id = ID_TS1;
    lk = PAD;
    ln = PAD;
    ts = 1'b1;
    case (sub)
      4'd2: id = ID_TS1;
      4'd3: id = ID_TS2;
      4'd4, 4'd5: lk = link;
      4'd6, 4'd7: begin
        lk = link;
        ln = lane;
      end
      4'd8: begin
        id = ID_TS2;
        lk = link;
        ln = lane;
      end
      default: ts = 1'b0;
    endcase
    if (ts)
      return {32'h0, {7{id}}, BYTE4,
              rate[7], upc, rate[5:0],
              PAD, lk, ln};
    return '0;
  endfunction

  // Out-of-range substates behave like detectQuiet.
  assign sub_in  = (substate > 4'd9) ? 4'd0 : substate;
  assign sent    = ((state == S_SEND) || (state == S_POST)) && txReady;
  assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
  assign rx_now  = rx_seen | rxDone;

  always_comb begin
    state_n   = state;
    sub_n     = sub_q;
    link_n    = link_q;
    lane_n    = lane_q;
    rate_n    = rate_q;
    upc_n     = upc_q;
    cnt_n     = cnt;
    rx_seen_n = rx_seen;
    if (start) begin
      sub_n     = sub_in;
      link_n    = linkNumber;
      lane_n    = laneNumber;
      rate_n    = rateId;
      upc_n     = upconfig;
      cnt_n     = '0;
      rx_seen_n = 1'b0;
      state_n   = active(sub_in) ? S_SEND : S_DONE;
    end else begin
      unique case (state)
        S_IDLE: state_n = S_IDLE;
        S_SEND: begin
          if (rxDone)
            rx_seen_n = 1'b1;
          if (sent) begin
            cnt_n = cnt_inc;
            case (sub_q)
              4'd2: begin
                if (rx_now && (cnt_inc >= MIN_CNT))
                  state_n = S_DONE;
              end
              4'd4, 4'd5, 4'd6, 4'd7: begin
                if (rx_now)
                  state_n = S_DONE;
              end
              default: begin
                if (rx_now) begin
                  state_n = S_POST;
                  cnt_n   = '0;
                end
              end
            endcase
          end
        end
        S_POST: begin
          if (sent) begin
            cnt_n = cnt_inc;
            if (cnt_inc >= POST_CNT)
              state_n = S_DONE;
          end
        end
        S_DONE: state_n = S_DONE;
        default: state_n = S_IDLE;
      endcase
    end
  end

  // DONE keeps the lane fed so the serializer is never starved.
  always_comb begin
    valid_n = (state_n == S_SEND) || (state_n == S_POST) ||
              ((state_n == S_DONE) && active(sub_n));
    word_n  = '0;
    if (valid_n)
      word_n = build_word(sub_n, link_n, lane_n, rate_n, upc_n);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      sub_q      <= '0;
      link_q     <= '0;
      lane_q     <= '0;
      rate_q     <= '0;
      upc_q      <= 1'b0;
      cnt        <= '0;
      rx_seen    <= 1'b0;
      orderedset <= '0;
      valid      <= 1'b0;
      txElecIdle <= 1'b1;
      txDone     <= 1'b0;
    end else begin
      state      <= state_n;
      sub_q      <= sub_n;
      link_q     <= link_n;
      lane_q     <= lane_n;
      rate_q     <= rate_n;
      upc_q      <= upc_n;
      cnt        <= cnt_n;
      rx_seen    <= rx_seen_n;
      orderedset <= word_n;
      valid      <= valid_n;
      txElecIdle <= !valid_n;
      txDone     <= (state_n == S_DONE);
    end
  end

endmodule

// File: tb/tb_tx_os_generator.sv
// Scoreboard bench for tx_os_generator with MIN_TS1=4, POST_TS=2.
// Expected words are queued at start and popped on each accepted word.
module tb_tx_os_generator;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [3:0]   substate;
  logic [7:0]   linkNumber;
  logic [7:0]   laneNumber;
  logic [7:0]   rateId;
  logic         upconfig;
  logic         rxDone;
  logic         txReady;
  logic [127:0] orderedset;
  logic         valid;
  logic         txElecIdle;
  logic         txDone;

  int total = 0;
  int bad   = 0;
  logic [127:0] sb[$];

  always #5 clk = ~clk;

  tx_os_generator #(
    .MIN_TS1(4),
    .POST_TS(2),
    .CNT_W(11)
  ) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .substate(substate),
    .linkNumber(linkNumber),
    .laneNumber(laneNumber),
    .rateId(rateId),
    .upconfig(upconfig),
    .rxDone(rxDone),
    .txReady(txReady),
    .orderedset(orderedset),
    .valid(valid),
    .txElecIdle(txElecIdle),
    .txDone(txDone)
  );

  function automatic logic [127:0] ts(
    input logic [7:0] id,
    input logic [7:0] lk,
    input logic [7:0] ln,
    input logic [7:0] b3
  );
    return {32'h0, {7{id}}, 8'hAA, b3, 8'hF7, lk, ln};
  endfunction

  task automatic do_start(
    input logic [3:0] s,
    input logic [7:0] lk,
    input logic [7:0] ln,
    input logic [7:0] rt,
    input logic       up
  );
    @(posedge clk); #1;
    start      = 1'b1;
    substate   = s;
    linkNumber = lk;
    laneNumber = ln;
    rateId     = rt;
    upconfig   = up;
    rxDone     = 1'b0;
    txReady    = 1'b0;
  endtask

  // Inputs are scrambled after start to prove the fields were latched.
  task automatic run_words(
    input int           n,
    input int           rx_from,
    input bit           pulse,
    input bit           toggle,
    input logic [127:0] w,
    input string        name
  );
    int sent = 0;
    int cyc  = 0;
    for (int i = 0; i < n; i++) sb.push_back(w);
    while (sb.size() > 0 && cyc < 100) begin
      @(posedge clk); #1;
      start      = 1'b0;
      substate   = 4'd0;
      linkNumber = 8'hEE;
      laneNumber = 8'hEE;
      rateId     = 8'h00;
      upconfig   = 1'b0;
      txReady    = toggle ? (cyc % 2 == 0) : 1'b1;
      rxDone     = pulse ? (sent + 1 == rx_from)
                         : (sent + 1 >= rx_from);
      @(negedge clk);
      total++;
      if (valid !== 1'b1 || txElecIdle !== 1'b0 || txDone !== 1'b0) begin
        bad++;
        $display("FAIL %s_busy word=%0d got v=%b ei=%b d=%b want 1 0 0",
                 name, sent + 1, valid, txElecIdle, txDone);
      end
      total++;
      if (orderedset !== sb[0]) begin
        bad++;
        $display("FAIL %s_word word=%0d got=%h want=%h",
                 name, sent + 1, orderedset, sb[0]);
      end
      if (txReady) begin
        void'(sb.pop_front());
        sent++;
      end
      cyc++;
    end
    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL %s_timeout got=%0d left want=0", name, sb.size());
      sb.delete();
    end
    @(posedge clk); #1;
    txReady = 1'b1;
    rxDone  = 1'b0;
    @(negedge clk);
    total++;
    if (txDone !== 1'b1 || valid !== 1'b1 || orderedset !== w) begin
      bad++;
      $display("FAIL %s_done got d=%b v=%b os=%h want 1 1 %h",
               name, txDone, valid, orderedset, w);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++;
    if (orderedset !== 128'h0 || valid !== 1'b0 ||
        txElecIdle !== 1'b1 || txDone !== 1'b0) begin
      bad++;
      $display("FAIL reset got os=%h v=%b ei=%b d=%b want 0 0 1 0",
               orderedset, valid, txElecIdle, txDone);
    end
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_polling_active;
    do_start(4'd2, 8'h11, 8'h22, 8'h02, 1'b1);
    run_words(4, 1, 1'b0, 1'b0,
              ts(8'h2A, 8'hF7, 8'hF7, 8'h42), "pa_min");
    do_start(4'd2, 8'h11, 8'h22, 8'h4F, 1'b0);
    run_words(7, 7, 1'b0, 1'b0,
              ts(8'h2A, 8'hF7, 8'hF7, 8'h0F), "pa_late");
  endtask

  task automatic test_post;
    do_start(4'd3, 8'h11, 8'h22, 8'h01, 1'b0);
    run_words(5, 3, 1'b1, 1'b0,
              ts(8'h25, 8'hF7, 8'hF7, 8'h01), "pc_pulse");
    do_start(4'd9, 8'h11, 8'h22, 8'h01, 1'b1);
    run_words(3, 1, 1'b0, 1'b0, 128'h0, "cfg_idle");
  endtask

  task automatic test_fields;
    do_start(4'd6, 8'h01, 8'h05, 8'hAA, 1'b0);
    run_words(3, 3, 1'b0, 1'b1,
              ts(8'h2A, 8'h01, 8'h05, 8'hAA), "lanenum");
    do_start(4'd4, 8'h22, 8'h33, 8'h80, 1'b1);
    run_words(2, 2, 1'b0, 1'b0,
              ts(8'h2A, 8'h22, 8'hF7, 8'hC0), "lw_start");
  endtask

  task automatic test_quiet;
    logic [3:0] subs [2];
    subs[0] = 4'd0;
    subs[1] = 4'd12;
    for (int i = 0; i < 2; i++) begin
      do_start(subs[i], 8'h01, 8'h02, 8'h03, 1'b1);
      @(posedge clk); #1;
      start   = 1'b0;
      txReady = 1'b1;
      @(negedge clk);
      total++;
      if (valid !== 1'b0 || txElecIdle !== 1'b1 ||
          txDone !== 1'b1 || orderedset !== 128'h0) begin
        bad++;
        $display("FAIL quiet sub=%0d got v=%b ei=%b d=%b want 0 1 1",
                 subs[i], valid, txElecIdle, txDone);
      end
    end
  endtask

  task automatic test_back_to_back;
    do_start(4'd2, 8'h11, 8'h22, 8'h02, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      start   = 1'b0;
      txReady = 1'b1;
      rxDone  = 1'b0;
    end
    @(negedge clk);
    total++;
    if (valid !== 1'b1 || txDone !== 1'b0) begin
      bad++;
      $display("FAIL mid_send got v=%b d=%b want 1 0", valid, txDone);
    end
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    total++;
    if (orderedset !== 128'h0 || valid !== 1'b0 ||
        txElecIdle !== 1'b1 || txDone !== 1'b0) begin
      bad++;
      $display("FAIL mid_reset got os=%h v=%b ei=%b d=%b want 0 0 1 0",
               orderedset, valid, txElecIdle, txDone);
    end
    do_start(4'd2, 8'h11, 8'h22, 8'h02, 1'b0);
    run_words(4, 1, 1'b0, 1'b0,
              ts(8'h2A, 8'hF7, 8'hF7, 8'h02), "after_reset");
    do_start(4'd8, 8'h03, 8'h07, 8'h02, 1'b0);
    run_words(3, 1, 1'b0, 1'b0,
              ts(8'h25, 8'h03, 8'h07, 8'h02), "cfg_complete");
  endtask

  initial begin
    reset      = 1'b1;
    start      = 1'b0;
    substate   = '0;
    linkNumber = '0;
    laneNumber = '0;
    rateId     = '0;
    upconfig   = 1'b0;
    rxDone     = 1'b0;
    txReady    = 1'b0;
    test_reset();
    test_polling_active();
    test_post();
    test_fields();
    test_quiet();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
